// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link (serializer and matching deserializer).
package serial_pkg;

   // Controller states of the serial transmit/receive engines
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit-order selectors for the MSB_FIRST parameter
   localparam bit MSB = 1'b1;
   localparam bit LSB = 1'b0;

   // Width of a counter that must hold the values 0..modulus-1.
   // A modulus of 1 still needs one bit so the port never collapses to zero width.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-WIDTH up counter with synchronous clear, zero-load and terminal flag.
module mod_counter
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic          load0,
   output logic [CW-1:0] count,
   output logic          at_max
);

   localparam logic [CW-1:0] MAX_VAL = CW'(WIDTH - 1);

   // Terminal value flag, used by the parent to recognise the final bit
   assign at_max = (count == MAX_VAL);

   // Count register: clear wins, then an explicit restart at zero, then wrap-around increment
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (load0) begin
         count <= '0;
      end else if (en) begin
         count <= at_max ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on load/ready and
// emits it one bit per clock with valid/last/done framing.
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = MSB
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] D,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic             done
);

   localparam int            CW      = cnt_width(WIDTH);
   localparam logic [CW-1:0] PENULT  = CW'(WIDTH - 2);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nx;
   logic             sout_nx;
   logic             valid_nx;
   logic             last_nx;
   logic             done_nx;
   logic             accept;
   logic             cnt_en;
   logic             cnt_load0;
   logic [CW-1:0]    count;
   logic             at_max;

   // Bit counter: tracks which position of the transmit order is currently on sout
   mod_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .clk    (clk),
      .clr    (clr),
      .en     (cnt_en),
      .load0  (cnt_load0),
      .count  (count),
      .at_max (at_max)
   );

   // Ready is the only unregistered output: idle, or presenting the final bit of a word
   assign ready  = (state == ST_IDLE) || ((state == ST_SHIFT) && at_max);
   assign accept = load && ready;

   // Next-state and next-output decode; the shift register always holds the
   // not-yet-sent bits aligned so the next one sits at the outgoing end
   always_comb begin
      state_nx  = state;
      shreg_nx  = shreg;
      sout_nx   = 1'b0;
      valid_nx  = 1'b0;
      last_nx   = 1'b0;
      done_nx   = last;
      cnt_en    = 1'b0;
      cnt_load0 = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx  = ST_SHIFT;
               cnt_load0 = 1'b1;
               valid_nx  = 1'b1;
               if (MSB_FIRST) begin
                  sout_nx  = D[WIDTH-1];
                  shreg_nx = {D[WIDTH-2:0], 1'b0};
               end else begin
                  sout_nx  = D[0];
                  shreg_nx = {1'b0, D[WIDTH-1:1]};
               end
            end
         end

         ST_SHIFT: begin
            if (at_max) begin
               if (accept) begin
                  state_nx  = ST_SHIFT;
                  cnt_load0 = 1'b1;
                  valid_nx  = 1'b1;
                  if (MSB_FIRST) begin
                     sout_nx  = D[WIDTH-1];
                     shreg_nx = {D[WIDTH-2:0], 1'b0};
                  end else begin
                     sout_nx  = D[0];
                     shreg_nx = {1'b0, D[WIDTH-1:1]};
                  end
               end else begin
                  state_nx  = ST_IDLE;
                  cnt_load0 = 1'b1;
                  shreg_nx  = '0;
               end
            end else begin
               cnt_en   = 1'b1;
               valid_nx = 1'b1;
               last_nx  = (count == PENULT);
               if (MSB_FIRST) begin
                  sout_nx  = shreg[WIDTH-1];
                  shreg_nx = {shreg[WIDTH-2:0], 1'b0};
               end else begin
                  sout_nx  = shreg[0];
                  shreg_nx = {1'b0, shreg[WIDTH-1:1]};
               end
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State, shift register and framing outputs; clr aborts any word in flight
   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         last       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         shreg      <= shreg_nx;
         sout       <= sout_nx;
         sout_valid <= valid_nx;
         last       <= last_nx;
         done       <= done_nx;
      end
   end

endmodule
